// File: rtl/copperv_read_arbiter_pkg.sv
// rtl/copperv_read_arbiter_pkg.sv - requester IDs and helpers shared by the read arbiter
package copperv_read_arbiter_pkg;

    localparam int ARB_ID_WIDTH = 1;

    typedef enum logic [ARB_ID_WIDTH-1:0] {
        ARB_ID_INST = 1'b0,
        ARB_ID_DATA = 1'b1
    } arb_id_e;

    function automatic arb_id_e arb_other(input arb_id_e id);
        return (id == ARB_ID_INST) ? ARB_ID_DATA : ARB_ID_INST;
    endfunction

endpackage

// File: rtl/copperv_read_arbiter_if.sv
// rtl/copperv_read_arbiter_if.sv - one read channel: address handshake plus data handshake
interface copperv_read_arbiter_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 addr_valid;
    logic                 addr_ready;
    logic [BUS_WIDTH-1:0] addr;
    logic                 data_valid;
    logic                 data_ready;
    logic [BUS_WIDTH-1:0] data;

    // master issues addresses and consumes data; slave is the side that serves reads
    modport master (
        output addr_valid, addr, data_ready,
        input  addr_ready, data_valid, data
    );

    modport slave (
        input  addr_valid, addr, data_ready,
        output addr_ready, data_valid, data
    );
endinterface

// File: rtl/copperv_read_arbiter_id_fifo.sv
// rtl/copperv_read_arbiter_id_fifo.sv - in-order FIFO of requester IDs for issued reads
module copperv_read_arbiter_id_fifo
    import copperv_read_arbiter_pkg::*;
#(
    parameter int   DEPTH = 4,
    localparam int  PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  arb_id_e          din,
    output arb_id_e          dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    arb_id_e          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end
endmodule

// File: rtl/copperv_read_arbiter.sv
// rtl/copperv_read_arbiter.sv - shares one in-order memory read port between instruction and data reads
module copperv_read_arbiter
    import copperv_read_arbiter_pkg::*;
#(
    parameter int BUS_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ROUND_ROBIN     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    copperv_read_arbiter_if.slave  ir,
    copperv_read_arbiter_if.slave  dr,
    copperv_read_arbiter_if.master mr
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                 r_addr_valid;
    logic [BUS_WIDTH-1:0] r_addr;
    arb_id_e              r_last_grant;

    logic                 w_slot_free;
    logic                 w_can_issue;
    logic                 w_grant_valid;
    arb_id_e              w_grant_id;
    logic [BUS_WIDTH-1:0] w_grant_addr;
    logic                 w_push;
    logic                 w_pop;
    arb_id_e              w_head;
    logic [CNT_W-1:0]     w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_has_head;

    // the full check looks at the registered count, so a pop this cycle cannot make room for a push
    assign w_slot_free = !r_addr_valid || mr.addr_ready;
    assign w_can_issue = !rst && w_slot_free && !w_full;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = ARB_ID_DATA;
        if (ir.addr_valid && dr.addr_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = (ROUND_ROBIN != 0) ? arb_other(r_last_grant) : ARB_ID_DATA;
        end else if (ir.addr_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ARB_ID_INST;
        end else if (dr.addr_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ARB_ID_DATA;
        end
        w_grant_addr = (w_grant_id == ARB_ID_INST) ? ir.addr : dr.addr;
    end

    assign w_push        = w_can_issue && w_grant_valid;
    assign ir.addr_ready = w_push && (w_grant_id == ARB_ID_INST);
    assign dr.addr_ready = w_push && (w_grant_id == ARB_ID_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_valid <= 1'b0;
            r_addr       <= '0;
            r_last_grant <= ARB_ID_DATA;
        end else if (w_push) begin
            r_addr_valid <= 1'b1;
            r_addr       <= w_grant_addr;
            r_last_grant <= w_grant_id;
        end else if (w_slot_free) begin
            r_addr_valid <= 1'b0;
        end
    end

    assign mr.addr_valid = r_addr_valid;
    assign mr.addr       = r_addr;

    copperv_read_arbiter_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_grant_id),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // responses with nothing outstanding are never acknowledged nor forwarded
    assign w_has_head    = (w_count != '0);
    assign ir.data_valid = mr.data_valid && w_has_head && (w_head == ARB_ID_INST);
    assign dr.data_valid = mr.data_valid && w_has_head && (w_head == ARB_ID_DATA);
    assign ir.data       = mr.data;
    assign dr.data       = mr.data;
    assign mr.data_ready = w_has_head && ((w_head == ARB_ID_INST) ? ir.data_ready : dr.data_ready);
    assign w_pop         = mr.data_valid && mr.data_ready && !w_empty;
endmodule

// File: tb/tb_copperv_read_arbiter.sv
// tb/tb_copperv_read_arbiter.sv - directed self-checking bench for copperv_read_arbiter
module tb_copperv_read_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    copperv_read_arbiter_if #(.BUS_WIDTH(32)) ir_rr ();
    copperv_read_arbiter_if #(.BUS_WIDTH(32)) dr_rr ();
    copperv_read_arbiter_if #(.BUS_WIDTH(32)) mr_rr ();
    copperv_read_arbiter_if #(.BUS_WIDTH(32)) ir_fp ();
    copperv_read_arbiter_if #(.BUS_WIDTH(32)) dr_fp ();
    copperv_read_arbiter_if #(.BUS_WIDTH(32)) mr_fp ();

    copperv_read_arbiter #(
        .BUS_WIDTH(32), .MAX_OUTSTANDING(4), .ROUND_ROBIN(1)
    ) dut_rr (
        .clk(clk), .rst(rst), .ir(ir_rr), .dr(dr_rr), .mr(mr_rr)
    );

    copperv_read_arbiter #(
        .BUS_WIDTH(32), .MAX_OUTSTANDING(4), .ROUND_ROBIN(0)
    ) dut_fp (
        .clk(clk), .rst(rst), .ir(ir_fp), .dr(dr_fp), .mr(mr_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ir_rr.addr_valid = 0; ir_rr.addr = '0; ir_rr.data_ready = 0;
        dr_rr.addr_valid = 0; dr_rr.addr = '0; dr_rr.data_ready = 0;
        mr_rr.addr_ready = 0; mr_rr.data_valid = 0; mr_rr.data = '0;
        ir_fp.addr_valid = 0; ir_fp.addr = '0; ir_fp.data_ready = 0;
        dr_fp.addr_valid = 0; dr_fp.addr = '0; dr_fp.data_ready = 0;
        mr_fp.addr_ready = 0; mr_fp.data_valid = 0; mr_fp.data = '0;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        ir_rr.addr_valid = 1; ir_rr.addr = 32'h55;
        mr_rr.data_valid = 1; mr_rr.data = 32'h1234; ir_rr.data_ready = 1;
        tick();
        @(negedge clk);
        checks++; if (mr_rr.addr_valid !== 1'b0) begin errors++; $display("FAIL reset_mr_addr_valid: got %b want 0", mr_rr.addr_valid); end
        checks++; if (mr_rr.addr !== 32'h0) begin errors++; $display("FAIL reset_mr_addr: got %h want 0", mr_rr.addr); end
        checks++; if (ir_rr.addr_ready !== 1'b0) begin errors++; $display("FAIL reset_ir_addr_ready: got %b want 0", ir_rr.addr_ready); end
        checks++; if (ir_rr.data_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_data_valid: got %b want 0", ir_rr.data_valid); end
        checks++; if (mr_rr.data_ready !== 1'b0) begin errors++; $display("FAIL reset_mr_data_ready: got %b want 0", mr_rr.data_ready); end
        tick();
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_idle();
        tick();
        ir_rr.addr_valid = 1; ir_rr.addr = 32'h100; mr_rr.addr_ready = 1;
        @(negedge clk);
        checks++; if (ir_rr.addr_ready !== 1'b1) begin errors++; $display("FAIL idle_ir_addr_ready: got %b want 1", ir_rr.addr_ready); end
        checks++; if (dr_rr.addr_ready !== 1'b0) begin errors++; $display("FAIL idle_dr_addr_ready: got %b want 0", dr_rr.addr_ready); end
        tick();
        ir_rr.addr_valid = 0;
        mr_rr.data_valid = 1; mr_rr.data = 32'hDEADBEEF; ir_rr.data_ready = 1;
        @(negedge clk);
        checks++; if (mr_rr.addr !== 32'h100) begin errors++; $display("FAIL idle_mr_addr: got %h want 00000100", mr_rr.addr); end
        checks++; if (mr_rr.addr_valid !== 1'b1) begin errors++; $display("FAIL idle_mr_addr_valid: got %b want 1", mr_rr.addr_valid); end
        checks++; if (ir_rr.data_valid !== 1'b1) begin errors++; $display("FAIL idle_ir_data_valid: got %b want 1", ir_rr.data_valid); end
        checks++; if (ir_rr.data !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_ir_data: got %h want deadbeef", ir_rr.data); end
        checks++; if (dr_rr.data_valid !== 1'b0) begin errors++; $display("FAIL idle_dr_data_valid: got %b want 0", dr_rr.data_valid); end
        checks++; if (mr_rr.data_ready !== 1'b1) begin errors++; $display("FAIL idle_mr_data_ready: got %b want 1", mr_rr.data_ready); end
        tick();
        mr_rr.data = 32'hBAD0BAD0;
        @(negedge clk);
        checks++; if (mr_rr.addr_valid !== 1'b0) begin errors++; $display("FAIL idle_mr_addr_valid_drop: got %b want 0", mr_rr.addr_valid); end
        checks++; if (mr_rr.data_ready !== 1'b0) begin errors++; $display("FAIL empty_mr_data_ready: got %b want 0", mr_rr.data_ready); end
        checks++; if (ir_rr.data_valid !== 1'b0) begin errors++; $display("FAIL empty_ir_data_valid: got %b want 0", ir_rr.data_valid); end
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        bit [0:3]    exp_g;
        logic [31:0] exp_addr [4];
        int          ni;
        int          nd;
        exp_g = 4'b0101;
        ni = 0;
        nd = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            ir_rr.addr_valid = 1; ir_rr.addr = 32'h1000 + 32'(ni * 4);
            dr_rr.addr_valid = 1; dr_rr.addr = 32'h2000 + 32'(nd * 4);
            mr_rr.addr_ready = 1;
            if (k < 4) begin
                if (exp_g[k] == 1'b0) begin exp_addr[k] = ir_rr.addr; ni++; end
                else begin exp_addr[k] = dr_rr.addr; nd++; end
            end
            @(negedge clk);
            if (k < 4) begin
                checks++; if (ir_rr.addr_ready !== !exp_g[k] || dr_rr.addr_ready !== exp_g[k]) begin
                    errors++; $display("FAIL rr_grant[%0d]: got ir=%b dr=%b want ir=%b dr=%b", k, ir_rr.addr_ready, dr_rr.addr_ready, !exp_g[k], exp_g[k]);
                end
            end else begin
                checks++; if (ir_rr.addr_ready !== 1'b0 || dr_rr.addr_ready !== 1'b0) begin
                    errors++; $display("FAIL rr_full_stall: got ir=%b dr=%b want 0 0", ir_rr.addr_ready, dr_rr.addr_ready);
                end
            end
            if (k > 0) begin
                checks++; if (mr_rr.addr !== exp_addr[k-1]) begin errors++; $display("FAIL rr_mr_addr[%0d]: got %h want %h", k-1, mr_rr.addr, exp_addr[k-1]); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            ir_rr.addr_valid = 0; dr_rr.addr_valid = 0;
            ir_rr.data_ready = 1; dr_rr.data_ready = 1;
            mr_rr.data_valid = 1; mr_rr.data = 32'hA0 + 32'(i);
            @(negedge clk);
            checks++; if (ir_rr.data_valid !== !exp_g[i] || dr_rr.data_valid !== exp_g[i]) begin
                errors++; $display("FAIL rr_resp_route[%0d]: got ir=%b dr=%b want ir=%b dr=%b", i, ir_rr.data_valid, dr_rr.data_valid, !exp_g[i], exp_g[i]);
            end
            checks++; if ((exp_g[i] ? dr_rr.data : ir_rr.data) !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL rr_resp_data[%0d]: got %h want %h", i, (exp_g[i] ? dr_rr.data : ir_rr.data), 32'hA0 + 32'(i));
            end
        end
        tick();
        @(negedge clk);
        checks++; if (mr_rr.data_ready !== 1'b0) begin errors++; $display("FAIL rr_drained: got mr_data_ready=%b want 0", mr_rr.data_ready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            ir_fp.addr_valid = (k < 3); ir_fp.addr = 32'h3000;
            dr_fp.addr_valid = (k < 3); dr_fp.addr = 32'h4000 + 32'(k * 4);
            mr_fp.addr_ready = 1;
            @(negedge clk);
            if (k < 3) begin
                checks++; if (dr_fp.addr_ready !== 1'b1 || ir_fp.addr_ready !== 1'b0) begin
                    errors++; $display("FAIL fp_grant[%0d]: got ir=%b dr=%b want ir=0 dr=1", k, ir_fp.addr_ready, dr_fp.addr_ready);
                end
            end
            if (k > 0) begin
                checks++; if (mr_fp.addr !== 32'h4000 + 32'((k - 1) * 4)) begin
                    errors++; $display("FAIL fp_mr_addr[%0d]: got %h want %h", k-1, mr_fp.addr, 32'h4000 + 32'((k - 1) * 4));
                end
            end
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            mr_rr.addr_ready = 1;
            ir_rr.addr_valid = (k < 7);
            ir_rr.addr = 32'h400 + 32'(((k < 4) ? k : 4) * 4);
            mr_rr.data_valid = (k == 5); mr_rr.data = 32'h55; ir_rr.data_ready = 1;
            @(negedge clk);
            if (k < 4) begin
                checks++; if (ir_rr.addr_ready !== 1'b1) begin errors++; $display("FAIL full_accept[%0d]: got %b want 1", k, ir_rr.addr_ready); end
            end else if (k < 6) begin
                checks++; if (ir_rr.addr_ready !== 1'b0) begin errors++; $display("FAIL full_stall[%0d]: got %b want 0", k, ir_rr.addr_ready); end
            end else if (k == 6) begin
                checks++; if (ir_rr.addr_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: got %b want 1", ir_rr.addr_ready); end
            end else begin
                checks++; if (mr_rr.addr !== 32'h410 || mr_rr.addr_valid !== 1'b1) begin
                    errors++; $display("FAIL full_fifth_addr: got %h/%b want 00000410/1", mr_rr.addr, mr_rr.addr_valid);
                end
            end
            if (k == 5) begin
                checks++; if (ir_rr.data_valid !== 1'b1 || mr_rr.data_ready !== 1'b1) begin
                    errors++; $display("FAIL full_pop: got data_valid=%b mr_data_ready=%b want 1 1", ir_rr.data_valid, mr_rr.data_ready);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        tick();
        dr_rr.addr_valid = 1; dr_rr.addr = 32'h300; mr_rr.addr_ready = 1;
        @(negedge clk);
        checks++; if (dr_rr.addr_ready !== 1'b1) begin errors++; $display("FAIL bp_dr_accept: got %b want 1", dr_rr.addr_ready); end
        for (int k = 0; k < 2; k++) begin
            tick();
            dr_rr.addr_valid = 0;
            mr_rr.data_valid = 1; mr_rr.data = 32'h12345678; dr_rr.data_ready = 0;
            @(negedge clk);
            checks++; if (mr_rr.data_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", k, mr_rr.data_ready); end
            checks++; if (dr_rr.data_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, dr_rr.data_valid); end
        end
        tick();
        dr_rr.data_ready = 1;
        @(negedge clk);
        checks++; if (mr_rr.data_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", mr_rr.data_ready); end
        checks++; if (dr_rr.data !== 32'h12345678) begin errors++; $display("FAIL bp_release_data: got %h want 12345678", dr_rr.data); end
        tick();
        mr_rr.data = 32'h87654321;
        @(negedge clk);
        checks++; if (dr_rr.data_valid !== 1'b0) begin errors++; $display("FAIL bp_popped: got dr_data_valid=%b want 0", dr_rr.data_valid); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            ir_rr.addr_valid = 1; ir_rr.addr = 32'h500 + 32'(k * 4); mr_rr.addr_ready = 1;
        end
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mr_rr.data_valid = 1; mr_rr.data = 32'hCAFE0001;
        ir_rr.data_ready = 1; dr_rr.data_ready = 1;
        @(negedge clk);
        checks++; if (mr_rr.addr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_mr_addr_valid: got %b want 0", mr_rr.addr_valid); end
        checks++; if (mr_rr.data_ready !== 1'b0) begin errors++; $display("FAIL rstmid_mr_data_ready: got %b want 0", mr_rr.data_ready); end
        checks++; if (ir_rr.data_valid !== 1'b0 || dr_rr.data_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_data_valid: got ir=%b dr=%b want 0 0", ir_rr.data_valid, dr_rr.data_valid);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_idle();
        test_round_robin();
        test_fixed_priority();
        test_full();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
